rca_att_cfg_sequencer: RTL
==========================

# rca_att_cfg_sequencer

Sequences all configuration writes into the accelerator trigger table (ATT) write port. It arbitrates between two requesters: single-field writes from the CPU control path and whole-entry reconfiguration requests from the hardware profiler. A profiler reconfiguration expands into an ordered write sequence: invalidate, drain, sbb address, loop start address, validate. An entry is therefore never live with a half-written address pair, and is never retargeted while the ATT is mid-injection.

## Interface
- XLEN, 32, data and address width
- NUM_RCAS, 4, number of ATT entries; index width is RW = $clog2(NUM_RCAS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_wr_valid  in  1  CPU field write request
- cpu_rca_addr  in  RW  target entry
- cpu_field_id  in  2  field: 0 = sbb_addr, 1 = loop_start_addr, 2 = valid, 3 = reserved
- cpu_field_value  in  XLEN  field value
- cpu_wr_ready  out  1  CPU write accepted when high with cpu_wr_valid
- prof_req_valid  in  1  profiler reconfiguration request
- prof_rca_addr  in  RW  target entry
- prof_sbb_addr  in  XLEN  new sbb address
- prof_loop_start_addr  in  XLEN  new loop start address
- prof_req_ready  out  1  profiler request accepted when high with prof_req_valid
- prof_done  out  1  one-cycle pulse in the cycle the entry is re-validated
- att_busy  in  1  ATT is between its first and second injected instruction
- att_wr_en  out  1  ATT field write strobe (registered)
- att_wr_rca_addr  out  RW  ATT write entry (registered)
- att_wr_field_id  out  2  ATT write field (registered)
- att_wr_field_value  out  XLEN  ATT write value (registered)
- busy  out  1  high whenever state is not IDLE

## Operation
- States are IDLE, INVAL, DRAIN, WR_SBB, WR_LOOP and VALIDATE.
- Request latch: on profiler acceptance, latch prof_rca_addr, prof_sbb_addr and prof_loop_start_addr. Changes on the prof_* inputs after acceptance are ignored.
- Arbitration happens only in IDLE.
  - A single requester wins.
  - If both requesters are valid, grant the requester that did not win the previous grant.
  - The last_grant flag resets to PROF, so the CPU wins the first tie.
- cpu_wr_ready = IDLE & !(prof_req_valid & last_grant==CPU).
- prof_req_ready = IDLE & !(cpu_wr_valid & last_grant==PROF).
- CPU grant: the next cycle drives att_wr_en=1 with the CPU entry, field and value. The state stays IDLE, so back-to-back CPU writes are allowed every cycle.
  - field_id 3 is accepted but att_wr_en stays 0 (dropped).
  - For field 2, only bit 0 of the value is meaningful.
- Profiler grant moves IDLE to INVAL. The sequence then runs as follows (att_wr_en=1 in each writing state):
  - INVAL: write field 2, value 0. Next state is DRAIN.
  - DRAIN: no write. Stay while att_busy=1; go to WR_SBB when att_busy=0.
  - WR_SBB: write field 0 with the latched sbb address. Next state is WR_LOOP.
  - WR_LOOP: write field 1 with the latched loop start address. Next state is VALIDATE.
  - VALIDATE: write field 2, value 1, and pulse prof_done. Next state is IDLE.
- Neither ready output is asserted outside IDLE.
- Reset values: state=IDLE, att_wr_en=0, att_wr_rca_addr=0, att_wr_field_id=0, att_wr_field_value=0, prof_done=0, busy=0, cpu_wr_ready and prof_req_ready per the IDLE equations.
- Reset mid-sequence: the sequence is abandoned with no further writes. The target entry is left invalid (safe state), and the profiler must re-request.

## Timing
- Acceptance happens at cycle T.
- CPU write latency: att_wr_en in cycle T+1.
- Profiler sequence with att_busy=0:
  - T+1: INVAL write
  - T+2: DRAIN, no write
  - T+3: sbb write
  - T+4: loop write
  - T+5: valid write, with prof_done=1
  - IDLE again in cycle T+6, and a new grant is possible in T+6.
- DRAIN lasts 1 + (number of consecutive att_busy=1 cycles sampled in DRAIN).
- att_busy is ignored in every state except DRAIN.
- att_wr_* outputs are registered, so they change only on clk edges.

## Test plan
- Reset, then a CPU write (entry 2, field 1, value 0x0000_1000) at T -> att_wr_en=1 at T+1 with entry 2, field 1, value 0x1000; busy stays 0.
- Profiler request (entry 1, sbb 0x200, loop 0x180), att_busy=0 -> writes at T+1 (f2=0), T+3 (f0=0x200), T+4 (f1=0x180), T+5 (f2=1); prof_done only at T+5.
- Same request with att_busy=1 for 3 cycles from T+2 -> the sbb write moves to T+6 and prof_done to T+8.
- Both requesters valid in IDLE after reset -> CPU granted first; on the next tie the profiler is granted; cpu_wr_ready=0 for the whole profiler sequence.
- CPU write with field_id 3 -> cpu_wr_ready=1 and att_wr_en stays 0.
- rst asserted in WR_LOOP -> next cycle state=IDLE, att_wr_en=0, no VALIDATE write, prof_done never pulses.

Source files
------------

// File: rtl/rca_att_cfg_sequencer_if.sv
// Bundles the CPU field-write, profiler reconfiguration and ATT write-port
// signals of the ATT configuration sequencer.
interface rca_att_cfg_sequencer_if #(
  parameter int XLEN = 32,
  parameter int RW   = 2
);
  logic            cpu_wr_valid;
  logic [RW-1:0]   cpu_rca_addr;
  logic [1:0]      cpu_field_id;
  logic [XLEN-1:0] cpu_field_value;
  logic            cpu_wr_ready;

  logic            prof_req_valid;
  logic [RW-1:0]   prof_rca_addr;
  logic [XLEN-1:0] prof_sbb_addr;
  logic [XLEN-1:0] prof_loop_start_addr;
  logic            prof_req_ready;
  logic            prof_done;

  logic            att_busy;
  logic            att_wr_en;
  logic [RW-1:0]   att_wr_rca_addr;
  logic [1:0]      att_wr_field_id;
  logic [XLEN-1:0] att_wr_field_value;
  logic            busy;

  // Sequencer side
  modport slave (
    input  cpu_wr_valid, cpu_rca_addr, cpu_field_id, cpu_field_value,
    output cpu_wr_ready,
    input  prof_req_valid, prof_rca_addr, prof_sbb_addr, prof_loop_start_addr,
    output prof_req_ready, prof_done,
    input  att_busy,
    output att_wr_en, att_wr_rca_addr, att_wr_field_id, att_wr_field_value, busy
  );

  // Requester / ATT side
  modport master (
    output cpu_wr_valid, cpu_rca_addr, cpu_field_id, cpu_field_value,
    input  cpu_wr_ready,
    output prof_req_valid, prof_rca_addr, prof_sbb_addr, prof_loop_start_addr,
    input  prof_req_ready, prof_done,
    output att_busy,
    input  att_wr_en, att_wr_rca_addr, att_wr_field_id, att_wr_field_value, busy
  );
endinterface

// File: rtl/rca_att_cfg_sequencer.sv
// Arbitrates CPU single-field writes and profiler whole-entry reconfigurations
// onto the ATT write port; a reconfiguration is invalidate, drain, sbb, loop, validate.
module rca_att_cfg_sequencer #(
  parameter int XLEN     = 32,
  parameter int NUM_RCAS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  rca_att_cfg_sequencer_if.slave  io_bus
);
  localparam int RW = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INVAL,
    S_DRAIN,
    S_WR_SBB,
    S_WR_LOOP,
    S_VALIDATE
  } state_t;

  localparam logic       GRANT_CPU  = 1'b0;
  localparam logic       GRANT_PROF = 1'b1;
  localparam logic [1:0] F_SBB      = 2'd0;
  localparam logic [1:0] F_LOOP     = 2'd1;
  localparam logic [1:0] F_VALID    = 2'd2;
  localparam logic [1:0] F_RSVD     = 2'd3;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_grant;

  logic [RW-1:0]   r_req_rca;
  logic [XLEN-1:0] r_req_sbb;
  logic [XLEN-1:0] r_req_loop;

  logic            r_wr_en;
  logic [RW-1:0]   r_wr_rca;
  logic [1:0]      r_wr_field;
  logic [XLEN-1:0] r_wr_value;

  logic            w_wr_en_nxt;
  logic [RW-1:0]   w_wr_rca_nxt;
  logic [1:0]      w_wr_field_nxt;
  logic [XLEN-1:0] w_wr_value_nxt;

  logic w_idle;
  logic w_cpu_rdy;
  logic w_prof_rdy;
  logic w_cpu_grant;
  logic w_prof_grant;

  function automatic logic [XLEN-1:0] valid_value(input logic b);
    return {{(XLEN-1){1'b0}}, b};
  endfunction

  // On a tie the requester that lost the previous grant is the only one made ready
  assign w_idle       = (r_state == S_IDLE);
  assign w_cpu_rdy    = w_idle & ~(io_bus.prof_req_valid & (r_last_grant == GRANT_CPU));
  assign w_prof_rdy   = w_idle & ~(io_bus.cpu_wr_valid & (r_last_grant == GRANT_PROF));
  assign w_cpu_grant  = io_bus.cpu_wr_valid & w_cpu_rdy;
  assign w_prof_grant = io_bus.prof_req_valid & w_prof_rdy;

  // Write-port values are computed for the state being entered, then registered
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en_nxt    = 1'b0;
    w_wr_rca_nxt   = r_wr_rca;
    w_wr_field_nxt = r_wr_field;
    w_wr_value_nxt = r_wr_value;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_grant) begin
          w_wr_en_nxt    = (io_bus.cpu_field_id != F_RSVD);
          w_wr_rca_nxt   = io_bus.cpu_rca_addr;
          w_wr_field_nxt = io_bus.cpu_field_id;
          w_wr_value_nxt = (io_bus.cpu_field_id == F_VALID) ?
                           valid_value(io_bus.cpu_field_value[0]) : io_bus.cpu_field_value;
        end else if (w_prof_grant) begin
          w_state_nxt    = S_INVAL;
          w_wr_en_nxt    = 1'b1;
          w_wr_rca_nxt   = io_bus.prof_rca_addr;
          w_wr_field_nxt = F_VALID;
          w_wr_value_nxt = valid_value(1'b0);
        end
      end
      S_INVAL: w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!io_bus.att_busy) begin
          w_state_nxt    = S_WR_SBB;
          w_wr_en_nxt    = 1'b1;
          w_wr_rca_nxt   = r_req_rca;
          w_wr_field_nxt = F_SBB;
          w_wr_value_nxt = r_req_sbb;
        end
      end
      S_WR_SBB: begin
        w_state_nxt    = S_WR_LOOP;
        w_wr_en_nxt    = 1'b1;
        w_wr_rca_nxt   = r_req_rca;
        w_wr_field_nxt = F_LOOP;
        w_wr_value_nxt = r_req_loop;
      end
      S_WR_LOOP: begin
        w_state_nxt    = S_VALIDATE;
        w_wr_en_nxt    = 1'b1;
        w_wr_rca_nxt   = r_req_rca;
        w_wr_field_nxt = F_VALID;
        w_wr_value_nxt = valid_value(1'b1);
      end
      S_VALIDATE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Reset abandons any sequence in flight; the entry stays invalidated
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_PROF;
      r_wr_en      <= 1'b0;
      r_wr_rca     <= '0;
      r_wr_field   <= '0;
      r_wr_value   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_rca   <= w_wr_rca_nxt;
      r_wr_field <= w_wr_field_nxt;
      r_wr_value <= w_wr_value_nxt;
      if (w_cpu_grant) begin
        r_last_grant <= GRANT_CPU;
      end else if (w_prof_grant) begin
        r_last_grant <= GRANT_PROF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_prof_grant) begin
      r_req_rca  <= io_bus.prof_rca_addr;
      r_req_sbb  <= io_bus.prof_sbb_addr;
      r_req_loop <= io_bus.prof_loop_start_addr;
    end
  end

  assign io_bus.cpu_wr_ready       = w_cpu_rdy;
  assign io_bus.prof_req_ready     = w_prof_rdy;
  assign io_bus.prof_done          = (r_state == S_VALIDATE);
  assign io_bus.busy               = ~w_idle;
  assign io_bus.att_wr_en          = r_wr_en;
  assign io_bus.att_wr_rca_addr    = r_wr_rca;
  assign io_bus.att_wr_field_id    = r_wr_field;
  assign io_bus.att_wr_field_value = r_wr_value;
endmodule
